// File: rtl/ws2812_rx.sv
// WS2812 single-wire receiver: synchronizes din, measures high-pulse widths and
// reassembles 24-bit words, with frame-gap detection and timing-error strobes.
module ws2812_rx #(
    parameter int SYNC_STAGES = 2,
    parameter int MIN_HIGH    = 7,
    parameter int BIT_THRESH  = 29,
    parameter int MAX_HIGH    = 72,
    parameter int RESET_LOW   = 2400,
    parameter int IDX_W       = 9
) (
    input  logic             clk_sb,
    input  logic             reset,
    input  logic             din,
    output logic [23:0]      rgb_data,
    output logic             rgb_valid,
    output logic [IDX_W-1:0] led_index,
    output logic             frame_done,
    output logic [IDX_W-1:0] led_count,
    output logic             err
);

    typedef enum logic [1:0] {SYNC, LOW, HIGH} state_t;

    localparam logic [11:0] MIN_HIGH_C   = 12'(MIN_HIGH);
    localparam logic [11:0] BIT_THRESH_C = 12'(BIT_THRESH);
    localparam logic [11:0] MAX_HIGH_C   = 12'(MAX_HIGH);
    localparam logic [11:0] RESET_LOW_C  = 12'(RESET_LOW);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s, s_prev_q, edge_s, rise_s, fall_s;
    logic [11:0]            cnt_q, cnt_d;
    logic                   gap_hit, new_bit;
    state_t                 state_q, state_d;
    logic [4:0]             bit_cnt_q, bit_cnt_d;
    logic [23:0]            shift_q, shift_d;
    logic [IDX_W-1:0]       word_q, word_d;
    logic [23:0]            rgb_data_q, rgb_data_d;
    logic                   rgb_valid_q, rgb_valid_d;
    logic [IDX_W-1:0]       led_index_q, led_index_d;
    logic                   frame_done_q, frame_done_d;
    logic [IDX_W-1:0]       led_count_q, led_count_d;
    logic                   err_q, err_d;

    always_ff @(posedge clk_sb or posedge reset) begin
        if (reset) begin
            sync_q   <= '0;
            s_prev_q <= 1'b0;
        end else begin
            sync_q[0] <= din;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            s_prev_q <= s;
        end
    end

    assign s      = sync_q[SYNC_STAGES-1];
    assign edge_s = s ^ s_prev_q;
    assign rise_s = s & ~s_prev_q;
    assign fall_s = ~s & s_prev_q;

    // cnt_d is the length of the current run of s including this cycle, so at a
    // falling edge cnt_q holds exactly the number of cycles s was high.
    always_comb begin
        if (edge_s)           cnt_d = 12'd1;
        else if (cnt_q != '1) cnt_d = cnt_q + 12'd1;
        else                  cnt_d = cnt_q;
    end

    assign gap_hit = ~s & (cnt_d == RESET_LOW_C);
    assign new_bit = (cnt_q >= BIT_THRESH_C);

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        word_d       = word_q;
        rgb_data_d   = rgb_data_q;
        rgb_valid_d  = 1'b0;
        led_index_d  = led_index_q;
        frame_done_d = 1'b0;
        led_count_d  = led_count_q;
        err_d        = 1'b0;
        case (state_q)
            SYNC: begin
                // Nothing decoded before re-sync may leak into the next frame.
                bit_cnt_d = '0;
                word_d    = '0;
                if (gap_hit) state_d = LOW;
            end
            LOW: begin
                if (rise_s) begin
                    state_d = HIGH;
                end else if (gap_hit) begin
                    if (word_q != '0 || bit_cnt_q != '0) begin
                        frame_done_d = 1'b1;
                        led_count_d  = word_q;
                    end
                    if (bit_cnt_q != '0) err_d = 1'b1;
                    bit_cnt_d = '0;
                    word_d    = '0;
                end
            end
            HIGH: begin
                if (s && cnt_d > MAX_HIGH_C) begin
                    err_d     = 1'b1;
                    bit_cnt_d = '0;
                    word_d    = '0;
                    state_d   = SYNC;
                end else if (fall_s) begin
                    if (cnt_q < MIN_HIGH_C) begin
                        err_d     = 1'b1;
                        bit_cnt_d = '0;
                        state_d   = SYNC;
                    end else begin
                        shift_d = {shift_q[22:0], new_bit};
                        state_d = LOW;
                        if (bit_cnt_q == 5'd23) begin
                            bit_cnt_d   = '0;
                            rgb_data_d  = {shift_q[22:0], new_bit};
                            rgb_valid_d = 1'b1;
                            led_index_d = word_q;
                            if (word_q != '1) word_d = word_q + 1'b1;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 5'd1;
                        end
                    end
                end
            end
            default: state_d = SYNC;
        endcase
    end

    always_ff @(posedge clk_sb or posedge reset) begin
        if (reset) begin
            cnt_q        <= '0;
            state_q      <= SYNC;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            word_q       <= '0;
            rgb_data_q   <= '0;
            rgb_valid_q  <= 1'b0;
            led_index_q  <= '0;
            frame_done_q <= 1'b0;
            led_count_q  <= '0;
            err_q        <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            word_q       <= word_d;
            rgb_data_q   <= rgb_data_d;
            rgb_valid_q  <= rgb_valid_d;
            led_index_q  <= led_index_d;
            frame_done_q <= frame_done_d;
            led_count_q  <= led_count_d;
            err_q        <= err_d;
        end
    end

    assign rgb_data   = rgb_data_q;
    assign rgb_valid  = rgb_valid_q;
    assign led_index  = led_index_q;
    assign frame_done = frame_done_q;
    assign led_count  = led_count_q;
    assign err        = err_q;

endmodule

// File: tb/tb_ws2812_rx.sv
// Directed bench for ws2812_rx: waveforms built cycle-by-cycle on din, decoded
// words and frame strobes captured by a monitor and checked per scenario.
module tb_ws2812_rx;

    logic        clk_sb = 1'b0;
    logic        reset;
    logic        din;
    logic [23:0] rgb_data;
    logic        rgb_valid;
    logic [8:0]  led_index;
    logic        frame_done;
    logic [8:0]  led_count;
    logic        err;

    int checks = 0;
    int errors = 0;

    logic [23:0] v_data[$];
    logic [8:0]  v_idx[$];
    logic [8:0]  fd_cnt[$];
    logic        fd_err[$];
    int          err_seen;

    ws2812_rx dut (
        .clk_sb(clk_sb), .reset(reset), .din(din),
        .rgb_data(rgb_data), .rgb_valid(rgb_valid), .led_index(led_index),
        .frame_done(frame_done), .led_count(led_count), .err(err)
    );

    always #10 clk_sb = ~clk_sb;

    always @(negedge clk_sb) begin
        if (rgb_valid) begin
            v_data.push_back(rgb_data);
            v_idx.push_back(led_index);
        end
        if (frame_done) begin
            fd_cnt.push_back(led_count);
            fd_err.push_back(err);
        end
        if (err) err_seen++;
    end

    task automatic clr();
        v_data.delete(); v_idx.delete(); fd_cnt.delete(); fd_err.delete();
        err_seen = 0;
    endtask

    task automatic send_high(input int n);
        din = 1'b1;
        repeat (n) @(negedge clk_sb);
    endtask

    task automatic send_low(input int n);
        din = 1'b0;
        repeat (n) @(negedge clk_sb);
    endtask

    task automatic send_word(input logic [23:0] w, input int t1, input int t0,
                             input int per, input int last_low);
        int th;
        for (int i = 23; i >= 0; i--) begin
            th = w[i] ? t1 : t0;
            send_high(th);
            send_low(i == 0 ? last_low : per - th);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; din = 1'b0;
        repeat (3) @(negedge clk_sb);
        checks++;
        if ({rgb_data, rgb_valid, led_index, frame_done, led_count, err} !== 61'd0) begin
            errors++; $display("FAIL reset_outputs got %h want 0",
                {rgb_data, rgb_valid, led_index, frame_done, led_count, err});
        end
        reset = 1'b0;
        @(negedge clk_sb);
        checks++;
        if ({rgb_data, rgb_valid, led_index, frame_done, led_count, err} !== 61'd0) begin
            errors++; $display("FAIL reset_release got %h want 0",
                {rgb_data, rgb_valid, led_index, frame_done, led_count, err});
        end
    endtask

    task automatic test_basic();
        clr();
        send_low(2500);
        send_word(24'hA5C31E, 38, 19, 60, 2500);
        checks++;
        if (v_data.size() != 1) begin
            errors++; $display("FAIL basic_valid_cnt got %0d want 1", v_data.size());
        end else begin
            checks++;
            if (v_data[0] !== 24'hA5C31E) begin
                errors++; $display("FAIL basic_data got %h want a5c31e", v_data[0]);
            end
            checks++;
            if (v_idx[0] !== 9'd0) begin
                errors++; $display("FAIL basic_index got %0d want 0", v_idx[0]);
            end
        end
        checks++;
        if (fd_cnt.size() != 1 || fd_cnt[0] !== 9'd1) begin
            errors++; $display("FAIL basic_frame got n=%0d cnt=%0d want n=1 cnt=1",
                fd_cnt.size(), led_count);
        end
        checks++;
        if (err_seen != 0) begin
            errors++; $display("FAIL basic_err got %0d want 0", err_seen);
        end
    endtask

    task automatic test_multi();
        logic [23:0] exp_w[3];
        exp_w[0] = 24'hFF0000; exp_w[1] = 24'h00FF00; exp_w[2] = 24'h0000FF;
        clr();
        send_word(exp_w[0], 38, 19, 60, 41);
        send_word(exp_w[1], 38, 19, 60, 22);
        send_word(exp_w[2], 38, 19, 60, 2500);
        checks++;
        if (v_data.size() != 3) begin
            errors++; $display("FAIL multi_valid_cnt got %0d want 3", v_data.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (v_data[i] !== exp_w[i] || v_idx[i] !== 9'(i)) begin
                    errors++; $display("FAIL multi_word%0d got %h/%0d want %h/%0d",
                        i, v_data[i], v_idx[i], exp_w[i], i);
                end
            end
        end
        checks++;
        if (fd_cnt.size() != 1 || led_count !== 9'd3) begin
            errors++; $display("FAIL multi_led_count got n=%0d cnt=%0d want n=1 cnt=3",
                fd_cnt.size(), led_count);
        end
        checks++;
        if (err_seen != 0) begin
            errors++; $display("FAIL multi_err got %0d want 0", err_seen);
        end
    endtask

    task automatic test_threshold();
        clr();
        send_word(24'hC30FF0, 29, 28, 60, 2500);
        send_word(24'h3CF00F, 72, 7, 100, 2500);
        checks++;
        if (v_data.size() != 2) begin
            errors++; $display("FAIL thresh_valid_cnt got %0d want 2", v_data.size());
        end else begin
            checks++;
            if (v_data[0] !== 24'hC30FF0) begin
                errors++; $display("FAIL thresh_28_29 got %h want c30ff0", v_data[0]);
            end
            checks++;
            if (v_data[1] !== 24'h3CF00F) begin
                errors++; $display("FAIL thresh_7_72 got %h want 3cf00f", v_data[1]);
            end
        end
        checks++;
        if (err_seen != 0 || fd_cnt.size() != 2) begin
            errors++; $display("FAIL thresh_frames got err=%0d fd=%0d want err=0 fd=2",
                err_seen, fd_cnt.size());
        end
    endtask

    task automatic test_glitch();
        clr();
        send_high(6);
        send_low(50);
        send_word(24'hFFFFFF, 38, 19, 60, 2500);
        checks++;
        if (err_seen != 1 || v_data.size() != 0 || fd_cnt.size() != 0) begin
            errors++; $display("FAIL glitch_sync got err=%0d v=%0d fd=%0d want 1/0/0",
                err_seen, v_data.size(), fd_cnt.size());
        end
        send_word(24'h123456, 38, 19, 60, 2500);
        checks++;
        if (v_data.size() != 1 || v_data[0] !== 24'h123456 || v_idx[0] !== 9'd0) begin
            errors++; $display("FAIL glitch_recover got n=%0d want 1 word 123456 idx 0",
                v_data.size());
        end
        checks++;
        if (fd_cnt.size() != 1 || led_count !== 9'd1 || err_seen != 1) begin
            errors++; $display("FAIL glitch_frame got fd=%0d cnt=%0d err=%0d want 1/1/1",
                fd_cnt.size(), led_count, err_seen);
        end
    endtask

    task automatic test_long();
        clr();
        send_high(80);
        send_low(50);
        send_word(24'h0000FF, 38, 19, 60, 2500);
        checks++;
        if (err_seen != 1 || v_data.size() != 0 || fd_cnt.size() != 0) begin
            errors++; $display("FAIL long_sync got err=%0d v=%0d fd=%0d want 1/0/0",
                err_seen, v_data.size(), fd_cnt.size());
        end
        send_word(24'h654321, 38, 19, 60, 2500);
        checks++;
        if (v_data.size() != 1 || v_data[0] !== 24'h654321) begin
            errors++; $display("FAIL long_recover got n=%0d want 1 word 654321", v_data.size());
        end
    endtask

    task automatic test_partial();
        clr();
        for (int i = 0; i < 10; i++) begin
            send_high((i % 2 == 0) ? 38 : 19);
            send_low(i == 9 ? 2500 : ((i % 2 == 0) ? 22 : 41));
        end
        checks++;
        if (fd_cnt.size() != 1) begin
            errors++; $display("FAIL partial_frame got %0d want 1", fd_cnt.size());
        end else begin
            checks++;
            if (fd_err[0] !== 1'b1) begin
                errors++; $display("FAIL partial_same_cycle got %b want 1", fd_err[0]);
            end
            checks++;
            if (fd_cnt[0] !== 9'd0) begin
                errors++; $display("FAIL partial_led_count got %0d want 0", fd_cnt[0]);
            end
        end
        checks++;
        if (v_data.size() != 0 || err_seen != 1) begin
            errors++; $display("FAIL partial_misc got v=%0d err=%0d want 0/1",
                v_data.size(), err_seen);
        end
    endtask

    task automatic test_startup();
        reset = 1'b1; din = 1'b0;
        repeat (3) @(negedge clk_sb);
        reset = 1'b0;
        clr();
        send_word(24'hAAAAAA, 38, 19, 60, 2399);
        send_word(24'h555555, 38, 19, 60, 2400);
        checks++;
        if (v_data.size() != 0 || err_seen != 0 || fd_cnt.size() != 0) begin
            errors++; $display("FAIL startup_ignored got v=%0d err=%0d fd=%0d want 0/0/0",
                v_data.size(), err_seen, fd_cnt.size());
        end
        send_word(24'h0F0F0F, 38, 19, 60, 2500);
        checks++;
        if (v_data.size() != 1 || v_data[0] !== 24'h0F0F0F || v_idx[0] !== 9'd0) begin
            errors++; $display("FAIL startup_armed got n=%0d want 1 word 0f0f0f idx 0",
                v_data.size());
        end
        checks++;
        if (fd_cnt.size() != 1 || led_count !== 9'd1) begin
            errors++; $display("FAIL startup_frame got fd=%0d cnt=%0d want 1/1",
                fd_cnt.size(), led_count);
        end
    endtask

    task automatic test_loopback();
        logic [23:0] words[16];
        int bad;
        for (int i = 0; i < 16; i++) words[i] = 24'($urandom);
        clr();
        for (int i = 0; i < 16; i++)
            send_word(words[i], 38, 19, 60, (i == 15) ? 2500 : 41);
        checks++;
        if (v_data.size() != 16) begin
            errors++; $display("FAIL loop_valid_cnt got %0d want 16", v_data.size());
        end else begin
            bad = 0;
            for (int i = 0; i < 16; i++)
                if (v_data[i] !== words[i] || v_idx[i] !== 9'(i)) bad++;
            checks++;
            if (bad != 0) begin
                errors++; $display("FAIL loop_words got %0d bad words want 0", bad);
            end
        end
        checks++;
        if (fd_cnt.size() != 1 || led_count !== 9'd16 || err_seen != 0) begin
            errors++; $display("FAIL loop_frame got fd=%0d cnt=%0d err=%0d want 1/16/0",
                fd_cnt.size(), led_count, err_seen);
        end
    endtask

    initial begin
        reset = 1'b1;
        din   = 1'b0;
        err_seen = 0;
        @(negedge clk_sb);
        test_reset();
        test_basic();
        test_multi();
        test_threshold();
        test_glitch();
        test_long();
        test_partial();
        test_startup();
        test_loopback();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ws2812_rx.md
Name: ws2812_rx

Overview:
- Decodes a WS2812 single-wire bit stream back into 24-bit words on the 48 MHz system bus clock.
- Is the receiving end of the WS2812 line that the controller drives.
- Used for on-board loopback self-test of the transmit path and for capturing an upstream LED chain.
- Emits one strobe per decoded word, a per-frame LED index and count, and error pulses for out-of-spec timing.

Parameters:
- SYNC_STAGES, 2: input synchronizer depth, in flops.
- MIN_HIGH, 7: high pulses shorter than this many cycles are glitches.
- BIT_THRESH, 29: high pulse of at least this many cycles decodes as 1; shorter decodes as 0. 0.6 us at 48 MHz.
- MAX_HIGH, 72: high pulse longer than this many cycles is an error. 1.5 us.
- RESET_LOW, 2400: a low gap of this many cycles ends a frame. 50 us.
- IDX_W, 9: width of the LED index and LED count.

Ports:
- clk_sb, input, 1: system bus clock, 48 MHz.
- reset, input, 1: asynchronous reset, active-high.
- din, input, 1: raw WS2812 line, asynchronous to clk_sb.
- rgb_data, output, 24: last decoded word. rgb_data[23] is the first bit on the wire.
- rgb_valid, output, 1: one-cycle strobe when rgb_data updates.
- led_index, output, IDX_W: position in the frame of the word on rgb_data, 0-based.
- frame_done, output, 1: one-cycle strobe at the end of a frame.
- led_count, output, IDX_W: number of complete words in the last frame. Held until the next frame_done.
- err, output, 1: one-cycle strobe on a timing violation.

Behaviour:
- Clock and reset: one clock, clk_sb. reset is asynchronous and active-high.
- Reset values: rgb_data=0, rgb_valid=0, led_index=0, frame_done=0, led_count=0, err=0. Synchronizer flops reset to 0. FSM resets to SYNC. Counters reset to 0.
- Input path: din passes through SYNC_STAGES flops to give s. Edges are detected by comparing s with its previous value.
- Counters:
  - pulse counter, 12 bits, saturating; cleared on every edge of s.
  - bit_cnt, 0..23.
  - shift register, 24 bits, MSB-first shift-in.
  - word counter, IDX_W bits, saturating at all-ones.
- SYNC state:
  - Waits for s low for RESET_LOW consecutive cycles, then goes to LOW.
  - Any high clears the count.
  - No outputs are produced in SYNC.
- LOW state:
  - On a rising edge: go to HIGH and clear the counter.
  - If the low count reaches RESET_LOW (fires once per gap):
    - If the word counter is nonzero or bit_cnt is nonzero: pulse frame_done, and load led_count from the word counter.
    - If bit_cnt is nonzero: also pulse err. The partial word is discarded.
    - Clear bit_cnt and the word counter. Stay in LOW.
- HIGH state:
  - If the count exceeds MAX_HIGH while s is still high: pulse err, discard the partial word, clear the word counter, go to SYNC.
  - On a falling edge with width < MIN_HIGH: pulse err, discard the partial word, go to SYNC.
  - Otherwise on a falling edge: shift in bit = (width >= BIT_THRESH), increment bit_cnt, go to LOW.
- Width definition: the number of clk_sb cycles s was 1.
- Word completion:
  - On the falling edge that completes bit 23, the next clock edge does three things: rgb_data takes the 24 bits, led_index takes the word counter, and rgb_valid pulses.
  - The word counter then increments and saturates. bit_cnt wraps to 0.
- Latency: rgb_valid is SYNC_STAGES+1 cycles after the falling edge of din.
- Simultaneous events: err and frame_done never pulse in the same cycle, except for the partial-word-at-gap case.
- No back-pressure: the consumer must accept rgb_valid. Minimum spacing between pulses is 24 bit periods.
- Reset mid-frame: all state clears and the FSM returns to SYNC. The first frame after reset is accepted only after a full RESET_LOW gap.

Test Plan:
- Basic decode: reset, then low 2400+ cycles, then 24 bits of 0xA5C31E (T1H=38, T0H=19, period 60 cycles), then low 2400 cycles -> one rgb_valid with rgb_data=0xA5C31E and led_index=0; frame_done with led_count=1; err never asserted.
- Multi-word frame: 3 words 0xFF0000, 0x00FF00, 0x0000FF back-to-back, then gap -> three rgb_valid pulses with led_index 0, 1, 2 and data in order; led_count=3.
- Threshold boundaries: highs of 28 and 29 cycles -> decode as 0 and 1 respectively. High of 6 cycles -> err, then SYNC. High of 73 cycles -> err, then SYNC; no rgb_valid until the next 2400-cycle gap is followed by a clean word.
- Partial word: 10 bits, then a 2400-cycle low -> frame_done and err in the same cycle; led_count=0; no rgb_valid.
- Startup sync: bits arrive before any 2400-cycle gap -> ignored. A gap of exactly 2399 cycles with bits after it is still ignored; 2400 cycles arms the decoder.
- Loopback: ws2812 transmitter output drives din, sending 16 random words -> every word matches; led_count=16; the transmitter's send_n and the frame gap correspond.
